// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W          = 32;
   localparam int unsigned DATA_W          = 32;
   localparam int unsigned STRB_W          = 4;
   localparam int unsigned CNT_W           = 8;
   localparam int unsigned TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_e;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/bus_timer.sv
// Saturating wait-cycle counter with timeout compare for the granted port.
module bus_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SAT   = '1;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick && (count != SAT)) begin
         count <= count + CNT_W'(1);
      end
   end

   // A zero TIMEOUT disables the compare entirely.
   assign expired = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (instruction/data) arbiter onto a single memory port with wait timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [STRB_W-1:0] mem_wstrb,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant,
   output logic              bus_err
);

   arb_state_e state, state_nxt;
   logic       last_m1;
   logic       own0, own1, sel_valid, timer_expired, timeout;
   mem_req_t   req;

   assign own0      = (state == ST_GNT0);
   assign own1      = (state == ST_GNT1);
   assign sel_valid = (own0 & m0_valid) | (own1 & m1_valid);
   assign timeout   = timer_expired & sel_valid & ~mem_ready;

   bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_IDLE),
      .tick    ((own0 | own1) & ~mem_ready),
      .expired (timer_expired)
   );

   // State and last-owner register; last_owner tracks whoever just left a grant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         last_m1 <= 1'b1;
      end else begin
         state <= state_nxt;
         if ((state != ST_IDLE) && (state_nxt == ST_IDLE)) begin
            last_m1 <= own1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (m0_valid && m1_valid) begin
               state_nxt = last_m1 ? ST_GNT0 : ST_GNT1;
            end else if (m0_valid) begin
               state_nxt = ST_GNT0;
            end else if (m1_valid) begin
               state_nxt = ST_GNT1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (!sel_valid || mem_ready || timeout) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output muxes: everything is zero unless a port owns the bus.
   always_comb begin
      req       = '0;
      mem_valid = 1'b0;
      m0_ready  = 1'b0;
      m1_ready  = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      grant     = GRANT_NONE;
      case (state)
         ST_GNT0: begin
            req.addr  = m0_addr;
            mem_valid = m0_valid & ~timeout;
            m0_ready  = mem_ready | timeout;
            m0_rdata  = timeout ? '0 : mem_rdata;
            grant     = GRANT_M0;
         end
         ST_GNT1: begin
            req.addr  = m1_addr;
            req.wdata = m1_wdata;
            req.wstrb = m1_wstrb;
            mem_valid = m1_valid & ~timeout;
            m1_ready  = mem_ready | timeout;
            m1_rdata  = timeout ? '0 : mem_rdata;
            grant     = GRANT_M1;
         end
         default: ;
      endcase
   end

   assign mem_addr  = req.addr;
   assign mem_wdata = req.wdata;
   assign mem_wstrb = req.wstrb;
   assign bus_err   = timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed sequences, random vs. model.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m1_valid, mem_ready;
   logic [31:0] m0_addr, m1_addr, m1_wdata, mem_rdata;
   logic [3:0]  m1_wstrb;
   logic        m0_ready, m1_ready, mem_valid, bus_err;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [1:0]  grant;

   int total = 0;
   int bad   = 0;

   // Reference state: owner 0 = none, 1 = m0, 2 = m1.
   int md_owner = 0;
   int md_wait  = 0;
   int md_last  = 2;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_valid  (m0_valid),
      .m0_ready  (m0_ready),
      .m0_addr   (m0_addr),
      .m0_rdata  (m0_rdata),
      .m1_valid  (m1_valid),
      .m1_ready  (m1_ready),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_wstrb  (m1_wstrb),
      .m1_rdata  (m1_rdata),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .grant     (grant),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   logic [137:0] act;
   assign act = {grant, bus_err, mem_valid, mem_addr, mem_wdata, mem_wstrb,
                 m0_ready, m0_rdata, m1_ready, m1_rdata};

   typedef struct {
      logic        rst, m0v, m1v, mr;
      logic [1:0]  g;
      logic        r0, r1, err, mv;
      logic [31:0] d0, d1;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(logic r, logic a, logic b, logic m, logic [1:0] g,
                               logic r0, logic r1, logic e, logic mv,
                               logic [31:0] d0, logic [31:0] d1);
      vec_t v;
      v.rst = r; v.m0v = a; v.m1v = b; v.mr = m; v.g = g;
      v.r0 = r0; v.r1 = r1; v.err = e; v.mv = mv; v.d0 = d0; v.d1 = d1;
      return v;
   endfunction

   task automatic chk(string name, logic [137:0] a, logic [137:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, a, e);
      end
   endtask

   function automatic logic model_timeout();
      logic v;
      v = (md_owner == 1) ? m0_valid : m1_valid;
      return rst && (md_owner != 0) && (TO != 0) && v && !mem_ready && (md_wait == TO - 1);
   endfunction

   function automatic logic [137:0] model_exp();
      logic [1:0]  g;
      logic        err, mv, r0, r1, to;
      logic [31:0] ad, wd, d0, d1;
      logic [3:0]  ws;
      g = 2'b00; err = 1'b0; mv = 1'b0; r0 = 1'b0; r1 = 1'b0;
      ad = '0; wd = '0; d0 = '0; d1 = '0; ws = '0;
      to = model_timeout();
      if (rst && md_owner == 1) begin
         g = 2'b01; err = to; mv = m0_valid && !to; ad = m0_addr;
         r0 = mem_ready || to; d0 = to ? 32'h0 : mem_rdata;
      end else if (rst && md_owner == 2) begin
         g = 2'b10; err = to; mv = m1_valid && !to; ad = m1_addr;
         wd = m1_wdata; ws = m1_wstrb;
         r1 = mem_ready || to; d1 = to ? 32'h0 : mem_rdata;
      end
      return {g, err, mv, ad, wd, ws, r0, d0, r1, d1};
   endfunction

   task automatic model_step();
      logic v;
      if (!rst) begin
         md_owner = 0; md_wait = 0; md_last = 2;
      end else if (md_owner == 0) begin
         if (m0_valid && m1_valid) md_owner = (md_last == 2) ? 1 : 2;
         else if (m0_valid)        md_owner = 1;
         else if (m1_valid)        md_owner = 2;
         md_wait = 0;
      end else begin
         v = (md_owner == 1) ? m0_valid : m1_valid;
         if (!v || mem_ready || model_timeout()) begin
            md_last = md_owner; md_owner = 0;
         end else if (md_wait < 255) begin
            md_wait++;
         end
      end
   endtask

   // Called #1 after inputs change: check against the model, advance it, move to next cycle.
   task automatic finish_cycle(string name);
      chk(name, act, model_exp());
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(logic r, logic a, logic b, logic m);
      rst = r; m0_valid = a; m1_valid = b; mem_ready = m;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] exp41 [9];
      localparam logic [31:0] DB = 32'hDEADBEEF;
      exp41 = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

      drive(1'b0, 1'b0, 1'b0, 1'b0);
      m0_addr = 32'h0000_0A00; m1_addr = 32'h100; m1_wdata = 32'h12345678;
      m1_wstrb = 4'b0011; mem_rdata = DB;

      //                rst m0v m1v mr  grant  r0 r1 err mv  d0     d1
      tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 0, 0, 0, 1, DB,    32'h0);
      tbl[3]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 1, 0, 0, 1, DB,    32'h0);
      tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 0, 1, 1, 0, 32'h0, 32'h0);
      tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 0, 0, 0, 0, DB,    32'h0);
      tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[13] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[14] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 0, 1, 0, 1, 32'h0, DB);
      tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[17] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 0, 0, 0, 1, 32'h0, DB);
      tbl[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[19] = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[20] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0);
      tbl[21] = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 0, 0, 0, 1, DB,    32'h0);

      @(negedge clk);

      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rst, tbl[i].m0v, tbl[i].m1v, tbl[i].mr);
         #1;
         chk($sformatf("vec%0d", i),
             138'({grant, m0_ready, m1_ready, bus_err, mem_valid, m0_rdata, m1_rdata}),
             138'({tbl[i].g, tbl[i].r0, tbl[i].r1, tbl[i].err, tbl[i].mv, tbl[i].d0, tbl[i].d1}));
         finish_cycle($sformatf("vec%0d_model", i));
      end

      // m0 read completing on its third granted cycle
      drive(1'b0, 1'b0, 1'b0, 1'b0); #1; finish_cycle("rd3_reset");
      drive(1'b1, 1'b1, 1'b0, 1'b0); #1;
      chk("rd3_idle_grant", 138'(grant), 138'(2'b00));
      finish_cycle("rd3_idle");
      for (int c = 1; c <= 3; c++) begin
         mem_ready = (c == 3); #1;
         chk($sformatf("rd3_c%0d", c), 138'({grant, m0_ready, m0_rdata}),
             138'({2'b01, (c == 3) ? 1'b1 : 1'b0, DB}));
         finish_cycle($sformatf("rd3_c%0d_model", c));
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0); #1;
      chk("rd3_after", 138'({grant, m0_ready}), 138'({2'b00, 1'b0}));
      finish_cycle("rd3_after_model");

      // contention with an always-ready memory alternates with one idle cycle between grants
      drive(1'b0, 1'b0, 1'b0, 1'b0); #1; finish_cycle("alt_reset");
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      for (int c = 0; c < 9; c++) begin
         #1;
         chk($sformatf("alt_c%0d", c), 138'(grant), 138'(exp41[c]));
         if (c == 3 || c == 7)
            chk($sformatf("alt_wr_c%0d", c),
                138'({mem_valid, mem_addr, mem_wdata, mem_wstrb, m0_ready, m0_rdata}),
                138'({1'b1, 32'h100, 32'h12345678, 4'b0011, 1'b0, 32'h0}));
         finish_cycle($sformatf("alt_c%0d_model", c));
      end

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 149) != 0);
         m0_valid  = ($urandom_range(0, 9) < 7);
         m1_valid  = ($urandom_range(0, 9) < 7);
         mem_ready = ($urandom_range(0, 9) < 3);
         m0_addr   = $urandom;
         m1_addr   = $urandom;
         m1_wdata  = $urandom;
         m1_wstrb  = 4'($urandom_range(0, 15));
         mem_rdata = $urandom;
         #1;
         finish_cycle($sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
